dmem_port_arbiter: RTL

Two-master arbiter sharing the single-port, BRAM-backed data memory (with its address-bit-31 MMIO window) between the CPU load/store unit (master 0) and the debug/loader port (master 1). Grants at most one access per cycle and drives the memory's ask and fetch addresses so that registered BRAM reads and MMIO reads return on the correct cycle. Returns each response to the master that issued it. Supports a bounded locked burst for master 1 so program loading cannot starve the CPU.

---
 rtl/dmem_arb_pkg.sv | 13 +
 rtl/dmem_rr_pick.sv | 35 +++
 rtl/dmem_port_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared ids, state type and defaults for the data-memory arbiter
package dmem_arb_pkg;

    localparam logic MASTER_CPU    = 1'b0;
    localparam logic MASTER_DBG    = 1'b1;
    localparam int   MAX_BURST_DEF = 16;

    typedef enum logic {
        ARB   = 1'b0,
        BURST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/dmem_rr_pick.sv
// rtl/dmem_rr_pick.sv - two-request round-robin picker with last-winner pointer
module dmem_rr_pick
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_upd,
    input  logic       i_winner,
    output logic       o_valid,
    output logic       o_pick
);

    // id of the master granted most recently; the other one wins a tie
    logic r_last;

    always_comb begin
        o_valid = |i_req;
        o_pick  = MASTER_CPU;
        if (&i_req) begin
            o_pick = ~r_last;
        end else if (i_req[1]) begin
            o_pick = MASTER_DBG;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= MASTER_DBG;
        end else if (i_upd) begin
            r_last <= i_winner;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - CPU/debug arbiter for the shared BRAM+MMIO data memory port
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEF
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rsp,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_lock,
    output logic        m1_gnt,
    output logic        m1_rsp,
    output logic [31:0] m1_rdata,
    output logic        mem_we,
    output logic [31:0] mem_ask_addr,
    output logic [31:0] mem_fetch_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] LP_MAX = 8'(MAX_BURST);

    arb_state_e  r_state;
    logic [7:0]  r_burst_cnt;
    logic        r_rsp_vld;
    logic        r_rsp_id;
    logic        r_rsp_we;
    logic [31:0] r_fetch_addr;

    logic w_rr_valid;
    logic w_rr_pick;
    logic w_burst_live;
    logic w_yield;
    logic w_any;
    logic w_win;
    logic w_rsp_live;

    dmem_rr_pick u_rr_pick (
        .clk      (clk),
        .reset    (reset),
        .i_req    ({m1_req, m0_req}),
        .i_upd    (w_any),
        .i_winner (w_win),
        .o_valid  (w_rr_valid),
        .o_pick   (w_rr_pick)
    );

    // a saturated burst yields exactly one slot to a waiting CPU
    always_comb begin
        w_burst_live = (r_state == BURST) && m1_req && m1_lock;
        w_yield      = w_burst_live && (r_burst_cnt >= LP_MAX) && m0_req;
        w_any        = 1'b0;
        w_win        = MASTER_CPU;
        if (!reset) begin
            if (w_yield) begin
                w_any = 1'b1;
                w_win = MASTER_CPU;
            end else if (w_burst_live) begin
                w_any = 1'b1;
                w_win = MASTER_DBG;
            end else begin
                w_any = w_rr_valid;
                w_win = w_rr_pick;
            end
        end
    end

    always_comb begin
        m0_gnt       = w_any && (w_win == MASTER_CPU);
        m1_gnt       = w_any && (w_win == MASTER_DBG);
        mem_we       = 1'b0;
        mem_ask_addr = 32'd0;
        mem_wdata    = 32'd0;
        if (m0_gnt) begin
            mem_we       = m0_we;
            mem_ask_addr = m0_addr;
            mem_wdata    = m0_wdata;
        end else if (m1_gnt) begin
            mem_we       = m1_we;
            mem_ask_addr = m1_addr;
            mem_wdata    = m1_wdata;
        end
    end

    // a response captured just before reset must not leak out during reset
    always_comb begin
        w_rsp_live     = r_rsp_vld && !reset;
        m0_rsp         = w_rsp_live && (r_rsp_id == MASTER_CPU);
        m1_rsp         = w_rsp_live && (r_rsp_id == MASTER_DBG);
        m0_rdata       = (m0_rsp && !r_rsp_we) ? mem_rdata : 32'd0;
        m1_rdata       = (m1_rsp && !r_rsp_we) ? mem_rdata : 32'd0;
        mem_fetch_addr = r_fetch_addr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ARB;
            r_burst_cnt  <= 8'd0;
            r_rsp_vld    <= 1'b0;
            r_rsp_id     <= MASTER_CPU;
            r_rsp_we     <= 1'b0;
            r_fetch_addr <= 32'd0;
        end else begin
            r_rsp_vld    <= w_any;
            r_rsp_id     <= w_win;
            r_rsp_we     <= mem_we;
            r_fetch_addr <= mem_ask_addr;
            if (m1_gnt && m1_lock) begin
                r_state <= BURST;
                if (r_state == ARB) begin
                    r_burst_cnt <= 8'd1;
                end else if (r_burst_cnt < LP_MAX) begin
                    r_burst_cnt <= r_burst_cnt + 8'd1;
                end
            end else begin
                r_state     <= ARB;
                r_burst_cnt <= 8'd0;
            end
        end
    end

endmodule
